// File: rtl/rv_plic_src_filter.sv
// Per-source interrupt conditioner: synchronise, polarity-correct and glitch-filter
// each raw line ahead of the PLIC gateway, with a registered change pulse per source.
module rv_plic_src_filter #(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNTW        = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] intr_raw_i,
    input  logic [N_SOURCE-1:0] polarity_i,
    input  logic [N_SOURCE-1:0] filt_en_i,
    input  logic [CNTW-1:0]     filt_cnt_i,
    output logic [N_SOURCE-1:0] intr_src_o,
    output logic [N_SOURCE-1:0] intr_chg_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "rv_plic_src_filter: SYNC_STAGES must be >= 2");
    end

    for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNTW-1:0]        cnt_q;
        logic                   f_q;
        logic                   f_prev_q;
        logic                   chg_q;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1] ^ polarity_i[i];

        // cnt_q only increments while below the threshold, so it can never wrap,
        // and the >= compare resolves at once if the threshold drops mid-count.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                sync_q   <= '0;
                cnt_q    <= '0;
                f_q      <= 1'b0;
                f_prev_q <= 1'b0;
                chg_q    <= 1'b0;
            end else begin
                sync_q   <= {sync_q[SYNC_STAGES-2:0], intr_raw_i[i]};
                f_prev_q <= f_q;
                chg_q    <= f_q ^ f_prev_q;
                if (!filt_en_i[i]) begin
                    f_q   <= s;
                    cnt_q <= '0;
                end else if (s == f_q) begin
                    cnt_q <= '0;
                end else if (cnt_q >= filt_cnt_i) begin
                    f_q   <= s;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign intr_src_o[i] = f_q;
        assign intr_chg_o[i] = chg_q;
    end

endmodule

// File: tb/tb_rv_plic_src_filter.sv
// Self-checking bench for rv_plic_src_filter: per-cycle scoreboard fed by a
// behavioural reference model, plus directed latency/boundary checks.
module tb_rv_plic_src_filter;

    localparam int N    = 32;
    localparam int CNTW = 8;

    typedef struct packed {
        logic [N-1:0] src;
        logic [N-1:0] chg;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    intr_raw;
    logic [N-1:0]    polarity;
    logic [N-1:0]    filt_en;
    logic [CNTW-1:0] filt_cnt;
    logic [N-1:0]    intr_src;
    logic [N-1:0]    intr_chg;

    int checkCount = 0;
    int passCount  = 0;

    exp_t sbQueue[$];

    // reference model state
    logic [N-1:0] mRaw1, mRaw2, mLevel, mLevelOld, mChg;
    int           mRun [N];

    rv_plic_src_filter #(.N_SOURCE(N), .SYNC_STAGES(2), .CNTW(CNTW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .intr_raw_i (intr_raw),
        .polarity_i (polarity),
        .filt_en_i  (filt_en),
        .filt_cnt_i (filt_cnt),
        .intr_src_o (intr_src),
        .intr_chg_o (intr_chg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic [N-1:0] raw, input logic [N-1:0] pol,
                                 input logic [N-1:0] en, input logic [CNTW-1:0] thr);
        intr_raw = raw;
        polarity = pol;
        filt_en  = en;
        filt_cnt = thr;
    endtask

    // Model: a level follows its polarity-corrected, twice-delayed input once that
    // input has disagreed for more than 'threshold' consecutive evaluations.
    task automatic modelStep();
        logic [N-1:0] sNow;
        exp_t e;
        if (!rst_n) begin
            mRaw1 = '0; mRaw2 = '0; mLevel = '0; mLevelOld = '0; mChg = '0;
            for (int i = 0; i < N; i++) mRun[i] = 0;
        end else begin
            sNow      = mRaw2 ^ polarity;
            mChg      = mLevel ^ mLevelOld;
            mLevelOld = mLevel;
            for (int i = 0; i < N; i++) begin
                if (!filt_en[i]) begin
                    mLevel[i] = sNow[i];
                    mRun[i]   = 0;
                end else if (sNow[i] != mLevel[i]) begin
                    mRun[i]++;
                    if (mRun[i] > int'(filt_cnt)) begin
                        mLevel[i] = sNow[i];
                        mRun[i]   = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
            end
            mRaw2 = mRaw1;
            mRaw1 = intr_raw;
        end
        e.src = mLevel;
        e.chg = mChg;
        sbQueue.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        if (sbQueue.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL sb_empty: got 0 entries, expected 1");
        end else begin
            e = sbQueue.pop_front();
            checkOutput("sb_src", intr_src, e.src);
            checkOutput("sb_chg", intr_chg, e.chg);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        logic [N-1:0] raw, pol, en;
        // source 0 is an idle active-low line from the start
        applyStimulus(32'h0000_0001, 32'h0000_0001, '0, 8'd0);
        rst_n = 1'b0;
        ticks(2);
        checkOutput("reset_src", intr_src, '0);
        checkOutput("reset_chg", intr_chg, '0);
        rst_n = 1'b1;
        ticks(8);
        checkOutput("pol_idle_src0", {31'b0, intr_src[0]}, '0);

        // test 1: bypass latency of 3 edges, change pulse one cycle later
        intr_raw[3] = 1'b1;
        ticks(2);
        checkOutput("byp_src3_early", {31'b0, intr_src[3]}, '0);
        tick();
        checkOutput("byp_src3", {31'b0, intr_src[3]}, 32'd1);
        checkOutput("byp_chg3_early", {31'b0, intr_chg[3]}, '0);
        tick();
        checkOutput("byp_chg3", {31'b0, intr_chg[3]}, 32'd1);
        tick();
        checkOutput("byp_chg3_end", {31'b0, intr_chg[3]}, '0);

        // test 2: glitch rejection with threshold 4
        filt_en[5] = 1'b1;
        filt_cnt   = 8'd4;
        intr_raw[5] = 1'b1;
        ticks(4);
        intr_raw[5] = 1'b0;
        ticks(10);
        checkOutput("glitch_src5", {31'b0, intr_src[5]}, '0);
        intr_raw[5] = 1'b1;
        ticks(5);
        intr_raw[5] = 1'b0;
        tick();
        checkOutput("filt_src5_early", {31'b0, intr_src[5]}, '0);
        tick();
        checkOutput("filt_src5", {31'b0, intr_src[5]}, 32'd1);
        ticks(10);

        // test 3: active-low source 0 asserted by driving the line low
        intr_raw[0] = 1'b0;
        ticks(2);
        checkOutput("pol_src0_early", {31'b0, intr_src[0]}, '0);
        tick();
        checkOutput("pol_src0", {31'b0, intr_src[0]}, 32'd1);

        // test 4: threshold lowered mid-count
        filt_en[7]  = 1'b1;
        filt_cnt    = 8'd200;
        intr_raw[7] = 1'b1;
        ticks(52);
        checkOutput("thr_src7_hold", {31'b0, intr_src[7]}, '0);
        filt_cnt = 8'd10;
        tick();
        checkOutput("thr_src7_flip", {31'b0, intr_src[7]}, 32'd1);

        // test 5: reset mid-count restarts the full window
        filt_en[9]  = 1'b1;
        filt_cnt    = 8'd6;
        intr_raw[9] = 1'b1;
        ticks(5);
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_src", intr_src, '0);
        checkOutput("midrst_chg", intr_chg, '0);
        rst_n = 1'b1;
        ticks(8);
        checkOutput("midrst_src9_early", {31'b0, intr_src[9]}, '0);
        tick();
        checkOutput("midrst_src9", {31'b0, intr_src[9]}, 32'd1);
        ticks(4);

        // test 6: all sources toggled together with mixed configuration
        pol = polarity;
        en  = filt_en;
        raw = intr_raw;
        for (int it = 0; it < 30; it++) begin
            if (it % 5 == 0) begin
                pol = $urandom;
                en  = $urandom;
            end
            raw = ~raw;
            applyStimulus(raw, pol, en, 8'($urandom_range(0, 3)));
            ticks($urandom_range(1, 8));
        end
        ticks(12);

        if (sbQueue.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL sb_leftover: got %0d entries, expected 0", sbQueue.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rv_plic_src_filter.md
Name: rv_plic_src_filter

Overview:
Per-source interrupt input conditioner. Sits directly upstream of the PLIC gateway and feeds its source inputs. Each raw, possibly asynchronous, interrupt line is synchronised, polarity-corrected and glitch-filtered, producing a clean level on intr_src_o for the gateway. It also emits a per-source change pulse for debug/status use.

Parameters:
N_SOURCE, 32, number of interrupt sources; matches PLIC N_SOURCE.
SYNC_STAGES, 2, synchroniser depth; legal values >= 2 (elaboration-time fatal otherwise).
CNTW, 8, width of each per-source filter counter and of filt_cnt_i.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
intr_raw_i  input  N_SOURCE  raw interrupt lines; may be asynchronous to clk_i
polarity_i  input  N_SOURCE  per source: 1 = active-low line (inverted after sync), 0 = active-high
filt_en_i  input  N_SOURCE  per source: 1 = glitch filter enabled, 0 = bypass
filt_cnt_i  input  CNTW  shared filter threshold; quasi-static, from a register
intr_src_o  output  N_SOURCE  conditioned interrupt level, to gateway src
intr_chg_o  output  N_SOURCE  one-cycle pulse when intr_src_o[i] toggles

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low. All flops update only on the rising edge of clk_i. The reset is sampled on that edge; no asynchronous reset terms.
- Reset values: all synchroniser flops 0, counters 0, intr_src_o = 0, intr_chg_o = 0.
- Reset mid-operation: the next edge with rst_ni = 0 clears all state, discarding any count in progress.
- Sync stage: sync[i] is the output of a SYNC_STAGES-deep flop chain on intr_raw_i[i].
- Polarity: s[i] = sync[i] XOR polarity_i[i]. Combinational; no extra stage.
- Filter state: per source, register f[i] (drives intr_src_o[i]) and counter cnt[i] (CNTW bits).
- Bypass (filt_en_i[i] = 0): f[i] <= s[i] and cnt[i] <= 0 every cycle.
- Filter enabled (filt_en_i[i] = 1), evaluated each cycle:
  - s[i] == f[i]: cnt[i] <= 0. Any glitch shorter than the threshold is discarded.
  - s[i] != f[i] and cnt[i] >= filt_cnt_i: f[i] <= s[i], cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i] + 1.
  - The counter never wraps. The >= compare guarantees resolution if filt_cnt_i is lowered mid-count.
- Net effect: a change must be present on s[i] for filt_cnt_i+1 consecutive cycles to propagate. filt_cnt_i = 0 behaves identically to bypass.
- Latency, intr_raw_i edge to intr_src_o edge:
  - Bypass: SYNC_STAGES+1 cycles.
  - Filtered: SYNC_STAGES+1+filt_cnt_i cycles.
- Change pulse: intr_chg_o[i] = 1 for exactly the cycle after f[i] changes, i.e. registered f[i] XOR previous f[i].
- Mode switch: toggling filt_en_i[i] takes effect on the next edge. Bypass→filter with s != f starts counting from cnt = 0. Filter→bypass forces f[i] = s[i] on the next edge.
- polarity_i toggle: treated as a data change on s[i] and filtered like any other transition.
  - Consequence: with polarity_i = 1 and the line idle (raw 0), s = 1 after reset. intr_src_o then rises after the normal latency.
  - Software must configure polarity before enabling the source in the PLIC.
- Independence: each source is independent; simultaneous transitions on all sources are handled in parallel. Only the filt_cnt_i threshold is shared.
- Module size: 120–250 lines of RTL (generate loop over N_SOURCE).

Test Plan:
1. Reset, bypass: intr_raw_i = 0, polarity_i = 0, filt_en_i = 0; assert rst_ni low for 2 cycles, release; raise intr_raw_i[3] at cycle 10 → intr_src_o[3] = 1 at cycle 13 (SYNC_STAGES = 2); intr_chg_o[3] pulses at cycle 14 only.
2. Glitch reject: filt_en_i[5] = 1, filt_cnt_i = 4; pulse intr_raw_i[5] high for 4 cycles → intr_src_o[5] stays 0, no intr_chg_o[5]. Same pulse held 5 cycles → intr_src_o[5] = 1, 7 cycles after the rising raw edge.
3. Polarity: polarity_i[0] = 1, intr_raw_i[0] = 1 (idle) → intr_src_o[0] = 0. Drive raw 0 → intr_src_o[0] = 1 after 3 cycles (bypass).
4. Threshold lowered mid-count: filt_cnt_i = 200, hold source 7 changed for 50 cycles, then set filt_cnt_i = 10 → intr_src_o[7] flips on the next edge. The counter must not wrap, and the flip must not be lost.
5. Reset mid-count: filter counting at cnt = 3 of 6, drive rst_ni = 0 for 1 cycle → outputs 0 on that edge. After release the full filt_cnt_i+1 window must restart.
6. All sources simultaneous: toggle all 32 raw bits together with mixed filt_en_i and polarity_i → each output matches an independent per-bit reference model, cycle-exact.
